// File: rtl/sensor_debounce_event_if.sv
// Event hand-off between the debounce stage and the home controller.
// The master holds one event; the slave accepts it with evt_ready.
interface sensor_debounce_event_if;
  logic evt_valid;
  logic evt_type;
  logic evt_ready;

  modport master (
    output evt_valid,
    output evt_type,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_type,
    output evt_ready
  );
endinterface

// File: rtl/sensor_debounce_event.sv
// Debounce filter for a synchronized sensor level, with edge pulses,
// a saturating rise counter and a one-entry event slot.
module sensor_debounce_event #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 8,
  parameter int REPORT_FALL     = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sync_in,
  input  logic                 enable,
  input  logic                 clr_count,
  output logic                 level,
  output logic                 rise_pulse,
  output logic                 fall_pulse,
  output logic [CNT_W-1:0]     event_count,
  output logic                 overflow,
  sensor_debounce_event_if.master evt
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] ONE  = DW'(1);

  typedef enum logic [1:0] {
    LOW, RISE_CHK, HIGH, FALL_CHK
  } state_t;

  state_t        state;
  logic [DW-1:0] cnt;
  logic          slot_valid;
  logic          slot_type;
  logic          push;
  logic          pop;
  logic          drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= LOW;
      cnt        <= '0;
      level      <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      unique case (state)
        LOW: begin
          if (enable && sync_in) begin
            state <= RISE_CHK;
            cnt   <= ONE;
          end
        end
        RISE_CHK: begin
          if (!enable || !sync_in) begin
            state <= LOW;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            state      <= HIGH;
            cnt        <= '0;
            level      <= 1'b1;
            rise_pulse <= 1'b1;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        HIGH: begin
          if (enable && !sync_in) begin
            state <= FALL_CHK;
            cnt   <= ONE;
          end
        end
        FALL_CHK: begin
          if (!enable || sync_in) begin
            state <= HIGH;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            state      <= LOW;
            cnt        <= '0;
            level      <= 1'b0;
            fall_pulse <= 1'b1;
          end else begin
            cnt <= cnt + ONE;
          end
        end
      endcase
    end
  end

  // Registered pulses feed the slot, so events land one cycle after them.
  assign push = rise_pulse | (fall_pulse & (REPORT_FALL != 0));
  assign pop  = slot_valid & evt.evt_ready;
  assign drop = push & slot_valid & ~pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_valid  <= 1'b0;
      slot_type   <= 1'b0;
      overflow    <= 1'b0;
      event_count <= '0;
    end else begin
      if (push && !drop) begin
        slot_valid <= 1'b1;
        slot_type  <= rise_pulse;
      end else if (pop) begin
        slot_valid <= 1'b0;
      end

      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_count) begin
        overflow <= 1'b0;
      end

      if (clr_count) begin
        event_count <= CNT_W'(rise_pulse);
      end else if (rise_pulse && event_count != '1) begin
        event_count <= event_count + 1'b1;
      end
    end
  end

  assign evt.evt_valid = slot_valid;
  assign evt.evt_type  = slot_type;

endmodule

// File: tb/tb_sensor_debounce_event.sv
// Randomized and directed checks of sensor_debounce_event against
// a sample-window reference model.
module tb_sensor_debounce_event;
  localparam int D     = 4;
  localparam int CW    = 4;
  localparam int CMAX  = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sync_in = 1'b0;
  logic          enable = 1'b1;
  logic          clr_count = 1'b0;
  logic          level;
  logic          rise_pulse;
  logic          fall_pulse;
  logic [CW-1:0] event_count;
  logic          overflow;

  sensor_debounce_event_if evt ();

  sensor_debounce_event #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W(CW),
    .REPORT_FALL(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sync_in(sync_in),
    .enable(enable),
    .clr_count(clr_count),
    .level(level),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .event_count(event_count),
    .overflow(overflow),
    .evt(evt.master)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: level flips once the last D samples are all enabled and opposite.
  int   hist[$];
  logic m_level, m_rise, m_fall, m_valid, m_type, m_ovf;
  int   m_cnt;

  function automatic void model_reset();
    hist.delete();
    m_level = 0; m_rise = 0; m_fall = 0;
    m_valid = 0; m_type = 0; m_ovf = 0; m_cnt = 0;
  endfunction

  function automatic void model_update(logic si, logic en, logic clr, logic rdy);
    logic o_rise, o_fall, push, pop, drop;
    bit   all_opp;
    o_rise = m_rise;
    o_fall = m_fall;
    m_rise = 0;
    m_fall = 0;
    hist.push_back(en ? int'(si) : 2);
    if (hist.size() > D) void'(hist.pop_front());
    all_opp = (hist.size() == D);
    foreach (hist[i]) if (hist[i] != int'(!m_level)) all_opp = 0;
    if (all_opp) begin
      m_level = !m_level;
      if (m_level) m_rise = 1; else m_fall = 1;
      hist.delete();
    end
    push = o_rise | o_fall;
    pop  = m_valid & rdy;
    drop = push & m_valid & !pop;
    if (push && !drop) begin
      m_valid = 1;
      m_type  = o_rise;
    end else if (pop) begin
      m_valid = 0;
    end
    if (drop) m_ovf = 1;
    else if (clr) m_ovf = 0;
    if (clr) m_cnt = o_rise ? 1 : 0;
    else if (o_rise) m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
  endfunction

  task automatic step(input logic si, input logic en,
                      input logic clr, input logic rdy);
    sync_in = si;
    enable = en;
    clr_count = clr;
    evt.evt_ready = rdy;
    @(posedge clk);
    model_update(si, en, clr, rdy);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sync_in = 0; enable = 1; clr_count = 0; evt.evt_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    logic [9:0] obs;
    do_reset();
    obs = {level, rise_pulse, fall_pulse, event_count,
           evt.evt_valid, evt.evt_type, overflow};
    n_checks++;
    if (obs !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b want=0", obs);
    end
  endtask

  task automatic test_rise();
    do_reset();
    for (int i = 1; i <= D; i++) begin
      step(1, 1, 0, 0);
      n_checks++;
      if ({level, rise_pulse} !== {2{i == D}}) begin
        n_fail++;
        $display("FAIL rise_edge%0d got=%b%b want=%0d", i, level, rise_pulse, i == D);
      end
    end
    step(1, 1, 0, 0);
    n_checks++;
    if ({rise_pulse, evt.evt_valid, evt.evt_type, event_count} !== {3'b011, 4'd1}) begin
      n_fail++;
      $display("FAIL rise_event got=%b%b%b cnt=%0d want=011 cnt=1",
               rise_pulse, evt.evt_valid, evt.evt_type, event_count);
    end
  endtask

  task automatic test_glitch();
    logic seen;
    do_reset();
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 0);
      seen |= rise_pulse;
    end
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 0);
      seen |= rise_pulse | fall_pulse;
    end
    n_checks++;
    if ({level, seen, evt.evt_valid} !== 3'b000) begin
      n_fail++;
      $display("FAIL glitch got lvl=%b pulse=%b valid=%b want=000",
               level, seen, evt.evt_valid);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    repeat (D) step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    repeat (D) step(0, 1, 0, 0);
    n_checks++;
    if (fall_pulse !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_fall got=%b want=1", fall_pulse);
    end
    step(0, 1, 0, 0);
    n_checks++;
    if ({evt.evt_valid, evt.evt_type, overflow} !== 3'b111) begin
      n_fail++;
      $display("FAIL ovf_drop got=%b%b%b want=111",
               evt.evt_valid, evt.evt_type, overflow);
    end
    step(0, 1, 0, 1);
    n_checks++;
    if ({evt.evt_valid, overflow} !== 2'b01) begin
      n_fail++;
      $display("FAIL ovf_pop got=%b%b want=01", evt.evt_valid, overflow);
    end
    step(0, 1, 1, 1);
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear got=%b want=0", overflow);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int k = 0; k < 17; k++) begin
      repeat (D) step(1, 1, 0, 1);
      repeat (D) step(0, 1, 0, 1);
    end
    step(0, 1, 0, 1);
    n_checks++;
    if (event_count !== 4'd15) begin
      n_fail++;
      $display("FAIL sat_count got=%0d want=15", event_count);
    end
    repeat (D) step(1, 1, 0, 1);
    step(1, 1, 1, 1);
    n_checks++;
    if (event_count !== 4'd1) begin
      n_fail++;
      $display("FAIL sat_clr_rise got=%0d want=1", event_count);
    end
  endtask

  task automatic test_enable();
    do_reset();
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    n_checks++;
    if (level !== 1'b0) begin
      n_fail++;
      $display("FAIL en_hold got=%b want=0", level);
    end
    for (int i = 1; i <= D; i++) begin
      step(1, 1, 0, 0);
      n_checks++;
      if (level !== (i == D)) begin
        n_fail++;
        $display("FAIL en_restart%0d got=%b want=%0d", i, level, i == D);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [9:0] obs;
    do_reset();
    repeat (D) step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    n_checks++;
    if ({level, evt.evt_valid} !== 2'b11) begin
      n_fail++;
      $display("FAIL arst_pre got=%b%b want=11", level, evt.evt_valid);
    end
    #1 rst_n = 1'b0;
    #1;
    obs = {level, rise_pulse, fall_pulse, event_count,
           evt.evt_valid, evt.evt_type, overflow};
    n_checks++;
    if (obs !== 10'd0) begin
      n_fail++;
      $display("FAIL arst_outputs got=%b want=0", obs);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_random();
    logic si, en, clr, rdy;
    do_reset();
    si = 0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 4) == 0) si = ~si;
      en  = ($urandom_range(0, 15) != 0);
      clr = ($urandom_range(0, 31) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      step(si, en, clr, rdy);
      n_checks++;
      if ({level, rise_pulse, fall_pulse, evt.evt_valid, evt.evt_type, overflow}
          !== {m_level, m_rise, m_fall, m_valid, m_type, m_ovf}
          || int'(event_count) != m_cnt) begin
        n_fail++;
        $display("FAIL random c=%0d got=%b%b%b%b%b%b cnt=%0d want=%b%b%b%b%b%b cnt=%0d",
                 c, level, rise_pulse, fall_pulse, evt.evt_valid, evt.evt_type,
                 overflow, event_count, m_level, m_rise, m_fall, m_valid,
                 m_type, m_ovf, m_cnt);
      end
    end
  endtask

  initial begin
    evt.evt_ready = 1'b0;
    model_reset();
    test_reset();
    test_rise();
    test_glitch();
    test_overflow();
    test_saturate();
    test_enable();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
